// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder.
// The optional misaligned-access error is enabled with the macro MEM_MISALIGN_ERR_EN.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Replace each byte lane of old_word whose strobe bit is set with the lane from new_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised storage with a byte-strobed synchronous write and a registered read.
// A single enable selects whether this cycle performs a read or a write.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= byte_merge(mem[idx], wdata, wstrb);
            end else begin
                rdata_q <= mem[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, held for LATENCY cycles, then answered.
// Define MEM_MISALIGN_ERR_EN to flag accesses with addr[1:0] != 0 instead of performing them.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    mem_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic              we_q;
    logic [IDX_W+1:0]  addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;

    logic              cur_we;
    logic [IDX_W+1:0]  cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [3:0]        cur_wstrb;
    logic              enter_resp;
    logic              misalign;
    logic              arr_en;
    logic [31:0]       arr_rdata;
    logic              unused_addr;

    // With LATENCY == 1 the array is accessed on the accepting edge, so use the live request.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_wstrb = wstrb_q;
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr[IDX_W+1:0];
            cur_wdata = req_wdata;
            cur_wstrb = req_wstrb;
        end
    end

    assign enter_resp = ((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                        ((state_q == WAIT) && (cnt_q == '0));

`ifdef MEM_MISALIGN_ERR_EN
    assign misalign    = (cur_addr[1:0] != 2'b00);
    assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];
`else
    assign misalign    = 1'b0;
    assign unused_addr = ^{req_addr[ADDR_W-1:IDX_W+2], cur_addr[1:0]};
`endif

    // Reset on the entry edge aborts the access, so the array is never touched.
    assign arr_en = enter_resp && !reset && !misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr[IDX_W+1:0];
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= misalign;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= misalign;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (cur_we),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .wstrb (cur_wstrb),
        .rdata (arr_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    // Writes and flagged accesses report zero data; the read register only matters in RESP.
    assign resp_rdata = (resp_valid_q && !we_q && !resp_err_q) ? arr_rdata : '0;

endmodule
